// File: rtl/secure_debug_port.sv
// Debug register-access port with key unlock, brute-force lockout and lifecycle gating.
// Optional idle auto-relock is built when DBG_RELOCK_TIMEOUT_EN is defined.
module secure_debug_port #(
    parameter int                 DATA_W         = 32,
    parameter int                 ADDR_W         = 8,
    parameter int                 NUM_REGS       = 16,
    parameter int                 PROT_BASE      = 8,
    parameter logic [DATA_W-1:0]  UNLOCK_KEY     = DATA_W'(32'hA5C3_0F1E),
    parameter int                 MAX_FAILS      = 3,
    parameter int                 LOCKOUT_CYCLES = 1024,
    parameter int                 IDLE_TIMEOUT   = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lc_prod,
    input  logic                          dbg_req,
    input  logic                          dbg_we,
    input  logic [ADDR_W-1:0]             dbg_addr,
    input  logic [DATA_W-1:0]             dbg_wdata,
    output logic [DATA_W-1:0]             dbg_rdata,
    output logic                          dbg_ack,
    output logic                          dbg_err,
    input  logic                          unlock_req,
    input  logic [DATA_W-1:0]             unlock_key,
    input  logic                          relock,
    output logic                          unlocked,
    output logic                          locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);
    localparam int FAIL_W = $clog2(MAX_FAILS+1);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LO_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_UNLOCKED = 2'd1;
    localparam logic [1:0] ST_LOCKOUT  = 2'd2;

    localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0]   PROT_A     = (ADDR_W+1)'(PROT_BASE);
    localparam logic [FAIL_W-1:0] MAX_F      = FAIL_W'(MAX_FAILS);
    localparam logic [LO_W-1:0]   LO_LOAD    = LO_W'(LOCKOUT_CYCLES - 1);

    logic [1:0]              state;
    logic [LO_W-1:0]         lo_cnt;
    logic [FAIL_W-1:0]       fail_inc;
    logic [DATA_W-1:0]       regs [NUM_REGS];
    logic [IDX_W-1:0]        idx;
    logic                    in_map, is_prot, is_shadow, deny, wr_ok, rd_ok;

    assign unlocked   = (state == ST_UNLOCKED);
    assign locked_out = (state == ST_LOCKOUT);
    assign fail_inc   = fail_cnt + 1'b1;

    // Decode uses the state registered before this edge, so a same-cycle unlock never applies.
    assign idx       = dbg_addr[IDX_W-1:0];
    assign in_map    = {1'b0, dbg_addr} <  NUM_REGS_A;
    assign is_prot   = {1'b0, dbg_addr} >= PROT_A;
    assign is_shadow = {1'b0, dbg_addr} == PROT_A;
    assign deny      = !in_map || (is_prot && !unlocked) || lc_prod;
    assign wr_ok     = dbg_req && dbg_we && !deny;
    assign rd_ok     = dbg_req && !dbg_we && !deny && !is_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack   <= dbg_req;
            dbg_err   <= dbg_req && deny;
            dbg_rdata <= rd_ok ? regs[idx] : '0;
            if (wr_ok) regs[idx] <= dbg_wdata;
        end
    end

`ifdef DBG_RELOCK_TIMEOUT_EN
    localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    logic [IDLE_W-1:0] idle_cnt;
`else
    logic idle_unused;
    assign idle_unused = (IDLE_TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst || lc_prod) begin
            state    <= ST_LOCKED;
            fail_cnt <= '0;
            lo_cnt   <= '0;
`ifdef DBG_RELOCK_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (unlock_req) begin
                        if (unlock_key == UNLOCK_KEY) begin
                            state    <= ST_UNLOCKED;
                            fail_cnt <= '0;
`ifdef DBG_RELOCK_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                        end else begin
                            fail_cnt <= fail_inc;
                            if (fail_inc == MAX_F) begin
                                state  <= ST_LOCKOUT;
                                lo_cnt <= LO_LOAD;
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (lo_cnt == '0) begin
                        state    <= ST_LOCKED;
                        fail_cnt <= '0;
                    end else begin
                        lo_cnt <= lo_cnt - 1'b1;
                    end
                end
                ST_UNLOCKED: begin
                    if (relock) begin
                        state <= ST_LOCKED;
                    end
`ifdef DBG_RELOCK_TIMEOUT_EN
                    // A request in the expiry cycle keeps the session alive.
                    else if (dbg_req)                idle_cnt <= '0;
                    else if (idle_cnt == IDLE_LAST)  state    <= ST_LOCKED;
                    else                             idle_cnt <= idle_cnt + 1'b1;
`endif
                end
                default: state <= ST_LOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_secure_debug_port.sv
// Directed self-checking bench for secure_debug_port (default parameters).
module tb_secure_debug_port;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lc_prod = 1'b0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic [31:0] dbg_rdata;
    logic        dbg_ack, dbg_err;
    logic        unlock_req = 1'b0;
    logic [31:0] unlock_key = '0;
    logic        relock = 1'b0;
    logic        unlocked, locked_out;
    logic [1:0]  fail_cnt;

    int nchk = 0;
    int nfail = 0;

    localparam logic [31:0] KEY = 32'hA5C3_0F1E;
    localparam logic [31:0] BAD = 32'h1234_5678;

    secure_debug_port dut (
        .clk(clk), .rst(rst), .lc_prod(lc_prod),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .unlock_req(unlock_req), .unlock_key(unlock_key), .relock(relock),
        .unlocked(unlocked), .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    // One access; outputs are left for the caller to inspect at edge+1.
    task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wd);
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
        @(posedge clk); #1;
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic pulse_unlock(input logic [31:0] key);
        @(negedge clk);
        unlock_req = 1'b1; unlock_key = key;
        @(posedge clk); #1;
        unlock_req = 1'b0;
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        relock = 1'b1;
        @(posedge clk); #1;
        relock = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        nchk++; if (dbg_ack !== 1'b0) begin nfail++; $display("FAIL rst_ack: got %b want 0", dbg_ack); end
        nchk++; if (dbg_err !== 1'b0) begin nfail++; $display("FAIL rst_err: got %b want 0", dbg_err); end
        nchk++; if (dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rst_rdata: got %h want 0", dbg_rdata); end
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL rst_unlocked: got %b want 0", unlocked); end
        nchk++; if (locked_out !== 1'b0) begin nfail++; $display("FAIL rst_locked_out: got %b want 0", locked_out); end
        nchk++; if (fail_cnt !== 2'd0) begin nfail++; $display("FAIL rst_fail_cnt: got %0d want 0", fail_cnt); end
    endtask

    task automatic test_open_access();
        access(1'b0, 8'd3, 32'h0);
        nchk++; if (dbg_ack !== 1'b1) begin nfail++; $display("FAIL rd3_ack: got %b want 1", dbg_ack); end
        nchk++; if (dbg_err !== 1'b0) begin nfail++; $display("FAIL rd3_err: got %b want 0", dbg_err); end
        nchk++; if (dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rd3_rdata: got %h want 0", dbg_rdata); end
        access(1'b1, 8'd3, 32'h1234);
        nchk++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b0 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL wr3_resp: got ack %b err %b rdata %h want 1 0 0", dbg_ack, dbg_err, dbg_rdata); end
        @(posedge clk); #1;
        nchk++; if (dbg_ack !== 1'b0 || dbg_err !== 1'b0 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL idle_resp: got ack %b err %b rdata %h want 0 0 0", dbg_ack, dbg_err, dbg_rdata); end
        access(1'b0, 8'd3, 32'h0);
        nchk++; if (dbg_rdata !== 32'h1234) begin nfail++; $display("FAIL rd3_after_wr: got %h want 00001234", dbg_rdata); end
        access(1'b0, 8'd7, 32'h0);
        nchk++; if (dbg_err !== 1'b0) begin nfail++; $display("FAIL rd7_locked_err: got %b want 0", dbg_err); end
    endtask

    task automatic test_protected();
        access(1'b1, 8'd9, 32'hDEAD);
        nchk++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL wr9_locked: got ack %b err %b rdata %h want 1 1 0", dbg_ack, dbg_err, dbg_rdata); end
        pulse_unlock(KEY);
        nchk++; if (unlocked !== 1'b1) begin nfail++; $display("FAIL unlock_good: got %b want 1", unlocked); end
        access(1'b0, 8'd9, 32'h0);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rd9_no_write: got err %b rdata %h want 0 0", dbg_err, dbg_rdata); end
        access(1'b1, 8'd9, 32'hDEAD);
        access(1'b0, 8'd9, 32'h0);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'hDEAD) begin nfail++; $display("FAIL rd9_unlocked: got err %b rdata %h want 0 0000dead", dbg_err, dbg_rdata); end
        pulse_relock();
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL relock: got %b want 0", unlocked); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'd5; dbg_wdata = 32'h77;
        @(posedge clk); #1;
        nchk++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b0) begin nfail++; $display("FAIL b2b_wr5: got ack %b err %b want 1 0", dbg_ack, dbg_err); end
        dbg_we = 1'b0;
        @(posedge clk); #1;
        nchk++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h77) begin nfail++; $display("FAIL b2b_rd5: got ack %b rdata %h want 1 00000077", dbg_ack, dbg_rdata); end
        dbg_addr = 8'd16;
        @(posedge clk); #1;
        nchk++; if (dbg_ack !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL b2b_rd16: got ack %b err %b rdata %h want 1 1 0", dbg_ack, dbg_err, dbg_rdata); end
        dbg_req = 1'b0;
    endtask

    task automatic test_lockout();
        int n;
        pulse_unlock(BAD);
        nchk++; if (fail_cnt !== 2'd1 || locked_out !== 1'b0) begin nfail++; $display("FAIL bad1: got cnt %0d lo %b want 1 0", fail_cnt, locked_out); end
        pulse_unlock(BAD);
        nchk++; if (fail_cnt !== 2'd2 || locked_out !== 1'b0) begin nfail++; $display("FAIL bad2: got cnt %0d lo %b want 2 0", fail_cnt, locked_out); end
        pulse_unlock(BAD);
        nchk++; if (locked_out !== 1'b1 || fail_cnt !== 2'd3) begin nfail++; $display("FAIL bad3: got lo %b cnt %0d want 1 3", locked_out, fail_cnt); end
        n = 0;
        pulse_unlock(KEY); n++;
        nchk++; if (unlocked !== 1'b0 || locked_out !== 1'b1 || fail_cnt !== 2'd3) begin nfail++; $display("FAIL key_in_lockout: got un %b lo %b cnt %0d want 0 1 3", unlocked, locked_out, fail_cnt); end
        pulse_relock(); n++;
        nchk++; if (locked_out !== 1'b1) begin nfail++; $display("FAIL relock_in_lockout: got %b want 1", locked_out); end
        while (locked_out && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        nchk++; if (n !== 1024) begin nfail++; $display("FAIL lockout_len: got %0d want 1024", n); end
        nchk++; if (locked_out !== 1'b0 || unlocked !== 1'b0 || fail_cnt !== 2'd0) begin nfail++; $display("FAIL lockout_exit: got lo %b un %b cnt %0d want 0 0 0", locked_out, unlocked, fail_cnt); end
    endtask

    task automatic test_unlocked_rules();
        pulse_unlock(KEY);
        access(1'b1, 8'd8, 32'h55);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL wr8: got err %b rdata %h want 0 0", dbg_err, dbg_rdata); end
        access(1'b0, 8'd8, 32'h0);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rd8_shadow: got err %b rdata %h want 0 0", dbg_err, dbg_rdata); end
        access(1'b0, 8'd16, 32'h0);
        nchk++; if (dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rd16: got err %b rdata %h want 1 0", dbg_err, dbg_rdata); end
        access(1'b1, 8'd15, 32'hF00D);
        access(1'b0, 8'd15, 32'h0);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'hF00D) begin nfail++; $display("FAIL rd15: got err %b rdata %h want 0 0000f00d", dbg_err, dbg_rdata); end
        pulse_unlock(BAD);
        nchk++; if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin nfail++; $display("FAIL bad_when_unlocked: got un %b cnt %0d want 1 0", unlocked, fail_cnt); end
    endtask

    task automatic test_lc_prod();
        @(negedge clk); lc_prod = 1'b1;
        @(posedge clk); #1;
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL lc_prod_lock: got %b want 0", unlocked); end
        access(1'b0, 8'd0, 32'h0);
        nchk++; if (dbg_err !== 1'b1) begin nfail++; $display("FAIL lc_prod_rd0: got %b want 1", dbg_err); end
        access(1'b0, 8'd3, 32'h0);
        nchk++; if (dbg_err !== 1'b1 || dbg_rdata !== 32'h0) begin nfail++; $display("FAIL lc_prod_rd3: got err %b rdata %h want 1 0", dbg_err, dbg_rdata); end
        pulse_unlock(KEY);
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL lc_prod_key: got %b want 0", unlocked); end
        @(negedge clk); lc_prod = 1'b0;
        pulse_unlock(BAD);
        pulse_unlock(BAD);
        pulse_unlock(BAD);
        @(negedge clk); lc_prod = 1'b1;
        @(posedge clk); #1;
        nchk++; if (locked_out !== 1'b0 || fail_cnt !== 2'd0) begin nfail++; $display("FAIL lc_prod_lockout: got lo %b cnt %0d want 0 0", locked_out, fail_cnt); end
        @(negedge clk); lc_prod = 1'b0;
    endtask

    task automatic test_same_cycle_unlock();
        @(negedge clk);
        unlock_req = 1'b1; unlock_key = KEY;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'd9;
        @(posedge clk); #1;
        unlock_req = 1'b0; dbg_req = 1'b0;
        nchk++; if (dbg_err !== 1'b1 || unlocked !== 1'b1) begin nfail++; $display("FAIL same_cycle: got err %b un %b want 1 1", dbg_err, unlocked); end
        access(1'b0, 8'd9, 32'h0);
        nchk++; if (dbg_err !== 1'b0 || dbg_rdata !== 32'hDEAD) begin nfail++; $display("FAIL after_unlock_rd9: got err %b rdata %h want 0 0000dead", dbg_err, dbg_rdata); end
`ifdef DBG_RELOCK_TIMEOUT_EN
        repeat (4095) @(posedge clk);
        #1;
        nchk++; if (unlocked !== 1'b1) begin nfail++; $display("FAIL idle_4095: got %b want 1", unlocked); end
        @(posedge clk); #1;
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL idle_expire: got %b want 0", unlocked); end
`else
        repeat (5000) @(posedge clk);
        #1;
        nchk++; if (unlocked !== 1'b1) begin nfail++; $display("FAIL no_idle_relock: got %b want 1", unlocked); end
        pulse_relock();
`endif
    endtask

    task automatic test_reset_mid();
        pulse_unlock(BAD);
        pulse_unlock(BAD);
        nchk++; if (fail_cnt !== 2'd2) begin nfail++; $display("FAIL pre_rst_cnt: got %0d want 2", fail_cnt); end
        pulse_reset();
        nchk++; if (fail_cnt !== 2'd0) begin nfail++; $display("FAIL rst_clears_cnt: got %0d want 0", fail_cnt); end
        pulse_unlock(KEY);
        pulse_reset();
        nchk++; if (unlocked !== 1'b0) begin nfail++; $display("FAIL rst_mid_session: got %b want 0", unlocked); end
        access(1'b0, 8'd3, 32'h0);
        nchk++; if (dbg_rdata !== 32'h0) begin nfail++; $display("FAIL rst_clears_regs: got %h want 0", dbg_rdata); end
    endtask

    initial begin
        test_reset();
        test_open_access();
        test_protected();
        test_back_to_back();
        test_lockout();
        test_unlocked_rules();
        test_lc_prod();
        test_same_cycle_unlock();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
